spi_slave_ctrl: RTL and testbench
=================================

Name: spi_slave_ctrl

Overview:
- SPI slave front-end controller that sequences the team's serial-in shift path and the RAM command interface.
- Collects a fixed-length command frame from MOSI while SS_n is low, then hands the frame to the RAM as a one-cycle rx_valid pulse.
- For read-data commands, waits for the RAM response and serialises it back on MISO.
- Sits between the SPI pins and the single-port RAM wrapper.

Parameters:
- DATA_WIDTH, 8, RAM data/address byte width; the frame is DATA_WIDTH+2 bits (2-bit command + payload).

Ports:
- clk_SPI  input  1  system clock; one SPI bit per rising edge.
- rst_SPI  input  1  asynchronous reset, active-high.
- SS_n  input  1  slave select, active-low; frame framing.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first; 0 when not transmitting.
- rx_data  output  DATA_WIDTH+2  captured frame; [DW+1:DW] = command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
- rx_valid  output  1  one-cycle pulse, rx_data valid.
- tx_data  input  DATA_WIDTH  read data from RAM.
- tx_valid  input  1  tx_data valid; sampled only in WAIT_TX.
- rd_addr_seen  output  1  set once a rd-addr frame has completed, cleared after a rd-data transfer.

Behaviour:
- Reset: state IDLE; rx_data=0, rx_valid=0, MISO=0, rd_addr_seen=0, bit counter=0, tx shift reg=0.
- SS_n high at any clock edge, in any state: next state IDLE; counter cleared, MISO=0, rx_valid=0.
  - rx_data holds its last value.
  - rd_addr_seen unchanged; an aborted frame never modifies it.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, TX, DONE.
- IDLE: SS_n low -> CHK_CMD. No bit captured in IDLE.
- CHK_CMD: MOSI sampled as frame bit DW+1 (first bit) into the shift register; counter=1.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift MOSI in each edge, MSB first; counter increments.
  - When the (DW+2)th bit is captured, rx_data <= full frame and rx_valid=1 for exactly the following cycle.
  - Frame-end transitions: WRITE -> DONE; READ_ADD -> DONE and rd_addr_seen <= 1; READ_DATA -> WAIT_TX.
- Latency: rx_valid asserts one cycle after the edge capturing the last bit. For DW=8, that is 10 edges after CHK_CMD entry.
- rx_data carries raw bits; command bits are not checked against the selected path.
- WAIT_TX: stay until tx_valid=1.
  - On that edge, latch tx_data into the tx shift reg and go to TX. No timeout.
  - tx_valid in any other state is ignored.
- TX: MISO = tx shift reg MSB, registered. First bit appears the cycle after the tx_valid edge.
  - Shift left each edge; DW bits total.
  - After the last bit: rd_addr_seen <= 0, MISO <= 0, go to DONE.
- DONE: ignore MOSI; MISO=0; remain until SS_n high, then IDLE.
- MOSI ignored outside CHK_CMD / WRITE / READ_ADD / READ_DATA.
- Async reset mid-frame: immediate return to reset values. A partial frame is discarded and produces no rx_valid.
- Back-to-back frames require SS_n high for at least one edge between them.

Test Plan:
- Write-address: reset; SS_n low; MOSI frame 00_1010_0101 -> one rx_valid pulse, rx_data=0x0A5, 10 edges after CHK_CMD entry; DONE until SS_n high; rd_addr_seen stays 0.
- Write-data: frame 01_1111_0000 -> rx_data=0x1F0, single rx_valid pulse; MISO stays 0 throughout.
- Read pair: frame 10_0011_0011 -> rx_data=0x233, rd_addr_seen=1.
  - Then frame 11_xxxx_xxxx -> rx_valid, state WAIT_TX.
  - tx_valid pulse with tx_data=0xC3 -> MISO sequence 1,1,0,0,0,0,1,1 on the next 8 cycles; rd_addr_seen=0 after.
- Abort: raise SS_n after 5 bits of a rd-addr frame -> no rx_valid, IDLE next cycle, rd_addr_seen remains 0.
  - Raise SS_n in WAIT_TX -> IDLE, MISO=0, later tx_valid ignored.
- Async reset asserted mid-TX (bit 3 of 0xAA) -> MISO=0, rx_valid=0, rd_addr_seen=0 immediately without a clock edge; next frame decodes normally.
- tx_valid asserted during WRITE frame -> ignored; rx_data and MISO unaffected.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end controller.
// Collects a (DATA_WIDTH+2)-bit command frame from MOSI while SS_n is low,
// presents it to the RAM with a one-cycle rx_valid pulse, and for read-data
// commands waits for the RAM response and serialises it MSB first on MISO.
module spi_slave_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_SPI,
  input  logic                  rst_SPI,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  rd_addr_seen
);

  localparam int FRAME_W = DATA_WIDTH + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  // Counter value when the final frame bit is on MOSI.
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(FRAME_W - 1);
  // Counter value once every response bit has been presented on MISO.
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    WAIT_TX,
    TX,
    DONE
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [FRAME_W-2:0]      rx_shift_q;   // all frame bits except the last one
  logic [DATA_WIDTH-1:0]   tx_shift_q;   // remaining response bits, MSB next
  logic                    miso_q;
  logic [FRAME_W-1:0]      rx_data_q;
  logic                    rx_valid_q;
  logic                    rd_addr_seen_q;
  logic [CNT_W-1:0]        cnt_d;

  assign cnt_d        = cnt_q + CNT_W'(1);
  assign MISO         = miso_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rd_addr_seen = rd_addr_seen_q;

  // Frame sequencer: SS_n high always wins and returns to IDLE without
  // touching rx_data or rd_addr_seen, so an aborted frame leaves no trace.
  always_ff @(posedge clk_SPI or posedge rst_SPI) begin
    if (rst_SPI) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (SS_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= CHK_CMD;
          end
          CHK_CMD: begin
            // First frame bit selects write vs. read; the read path then
            // depends on whether an address has already been supplied.
            rx_shift_q <= {{(FRAME_W - 2){1'b0}}, MOSI};
            cnt_q      <= CNT_W'(1);
            if (!MOSI) begin
              state_q <= WRITE;
            end else if (rd_addr_seen_q) begin
              state_q <= READ_DATA;
            end else begin
              state_q <= READ_ADD;
            end
          end
          WRITE, READ_ADD, READ_DATA: begin
            rx_shift_q <= {rx_shift_q[FRAME_W-3:0], MOSI};
            cnt_q      <= cnt_d;
            if (cnt_q == LAST_RX) begin
              rx_data_q  <= {rx_shift_q, MOSI};
              rx_valid_q <= 1'b1;
              if (state_q == READ_DATA) begin
                state_q <= WAIT_TX;
              end else begin
                state_q <= DONE;
              end
              if (state_q == READ_ADD) begin
                rd_addr_seen_q <= 1'b1;
              end
            end
          end
          WAIT_TX: begin
            // Drive the MSB straight away so it is on MISO the next cycle.
            if (tx_valid) begin
              miso_q     <= tx_data[DATA_WIDTH-1];
              tx_shift_q <= {tx_data[DATA_WIDTH-2:0], 1'b0};
              cnt_q      <= CNT_W'(1);
              state_q    <= TX;
            end
          end
          TX: begin
            if (cnt_q == LAST_TX) begin
              miso_q         <= 1'b0;
              rd_addr_seen_q <= 1'b0;
              state_q        <= DONE;
            end else begin
              miso_q     <= tx_shift_q[DATA_WIDTH-1];
              tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
              cnt_q      <= cnt_d;
            end
          end
          DONE: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed testbench for spi_slave_ctrl (DATA_WIDTH = 8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_spi_slave_ctrl;

  logic       clk_SPI = 1'b0;
  logic       rst_SPI;
  logic       SS_n;
  logic       MOSI;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       rd_addr_seen;

  int checks = 0;
  int errors = 0;

  spi_slave_ctrl #(.DATA_WIDTH(8)) dut (
    .clk_SPI      (clk_SPI),
    .rst_SPI      (rst_SPI),
    .SS_n         (SS_n),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .rd_addr_seen (rd_addr_seen)
  );

  always #5 clk_SPI = ~clk_SPI;

  task automatic tick();
    @(negedge clk_SPI);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drop SS_n, clock out a full 10-bit frame MSB first and check that
  // rx_valid pulses exactly once, on the cycle after the last bit.
  task automatic send_frame(input logic [9:0] f);
    SS_n = 1'b0;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = f[i];
      chk("rx_valid_early", {31'd0, rx_valid}, 32'd0);
      chk("miso_during_rx", {31'd0, MISO}, 32'd0);
      tick();
    end
    chk("rx_valid_pulse", {31'd0, rx_valid}, 32'd1);
    chk("rx_data", {22'd0, rx_data}, {22'd0, f});
    MOSI = 1'b0;
    tick();
    chk("rx_valid_single", {31'd0, rx_valid}, 32'd0);
  endtask

  task automatic release_ss();
    SS_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] resp;
    logic [7:0] resp2;

    rst_SPI  = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick();
    chk("rst_miso", {31'd0, MISO}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {22'd0, rx_data}, 32'd0);
    chk("rst_rd_addr_seen", {31'd0, rd_addr_seen}, 32'd0);
    rst_SPI = 1'b0;
    tick();

    // Write-address frame, then hold in DONE with MOSI activity
    send_frame(10'h0A5);
    chk("wa_rd_addr_seen", {31'd0, rd_addr_seen}, 32'd0);
    MOSI = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("done_miso", {31'd0, MISO}, 32'd0);
    end
    release_ss();

    // Write-data frame with tx_valid held high throughout (must be ignored)
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    send_frame(10'h1F0);
    tick();
    chk("wd_miso", {31'd0, MISO}, 32'd0);
    chk("wd_rx_data_hold", {22'd0, rx_data}, 32'h1F0);
    tx_valid = 1'b0;
    release_ss();

    // Abort a rd-addr frame after 5 bits
    SS_n = 1'b0;
    tick();
    MOSI = 1'b1; tick();
    MOSI = 1'b0; tick();
    MOSI = 1'b0; tick();
    MOSI = 1'b0; tick();
    MOSI = 1'b1; tick();
    SS_n = 1'b1;
    tick();
    chk("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("abort_rd_addr_seen", {31'd0, rd_addr_seen}, 32'd0);
    chk("abort_rx_data_hold", {22'd0, rx_data}, 32'h1F0);
    tick();
    chk("abort_rx_valid2", {31'd0, rx_valid}, 32'd0);

    // Read pair: rd-addr then rd-data with response 0xC3
    send_frame(10'h233);
    chk("ra_rd_addr_seen", {31'd0, rd_addr_seen}, 32'd1);
    release_ss();
    send_frame(10'h355);
    tick();
    chk("wait_tx_miso", {31'd0, MISO}, 32'd0);
    resp     = 8'hC3;
    tx_data  = resp;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      chk($sformatf("tx_c3_bit%0d", i), {31'd0, MISO}, {31'd0, resp[i]});
      chk("tx_rd_addr_seen", {31'd0, rd_addr_seen}, 32'd1);
      tick();
    end
    chk("tx_end_miso", {31'd0, MISO}, 32'd0);
    chk("tx_end_rd_addr_seen", {31'd0, rd_addr_seen}, 32'd0);
    release_ss();

    // Abort in WAIT_TX; later tx_valid must be ignored
    send_frame(10'h211);
    chk("ra2_rd_addr_seen", {31'd0, rd_addr_seen}, 32'd1);
    release_ss();
    send_frame(10'h3EE);
    SS_n = 1'b1;
    tick();
    chk("wtx_abort_miso", {31'd0, MISO}, 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    chk("wtx_late_miso", {31'd0, MISO}, 32'd0);
    tick();
    chk("wtx_late_miso2", {31'd0, MISO}, 32'd0);
    chk("wtx_abort_rd_addr_seen", {31'd0, rd_addr_seen}, 32'd1);

    // rd_addr_seen still set: next 1x frame is rd-data; reset mid-TX of 0xAA
    send_frame(10'h30F);
    resp2    = 8'hAA;
    tx_data  = resp2;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 7; i >= 3; i--) begin
      chk($sformatf("tx_aa_bit%0d", i), {31'd0, MISO}, {31'd0, resp2[i]});
      if (i != 3) tick();
    end
    #2 rst_SPI = 1'b1;
    #1;
    chk("arst_miso", {31'd0, MISO}, 32'd0);
    chk("arst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("arst_rd_addr_seen", {31'd0, rd_addr_seen}, 32'd0);
    chk("arst_rx_data", {22'd0, rx_data}, 32'd0);
    tick();
    rst_SPI = 1'b0;
    SS_n    = 1'b1;
    tick();

    // Normal decode after reset; rd-addr path proves rd_addr_seen was cleared
    send_frame(10'h0A5);
    chk("post_rst_rd_addr_seen", {31'd0, rd_addr_seen}, 32'd0);
    release_ss();
    send_frame(10'h2C4);
    chk("post_rst_ra_seen", {31'd0, rd_addr_seen}, 32'd1);
    release_ss();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
